req_ack_rr_ctrl: RTL
====================

// Module: req_ack_rr_ctrl
// PURPOSE
//  Multi-channel request/acknowledge controller: NCH requesters share one slave engine.
//  Round-robin arbitration picks one pending requester, pulses slave start, waits for slave
//  ready with a programmable timeout, then pulses ack (or err on timeout) to the granted
//  channel. It is the parametrised successor of the single-channel req/ack controller,
//  adding channel count, fairness and timeout recovery.
// PARAMETERS
//  NCH      4   number of requesting channels (>=2)
//  IDW      2   grant id width = $clog2(NCH)
//  TMO_W    4   width of the WORKING-state timeout counter
//  TIMEOUT  15  WORKING cycles without ready before abort (1..2**TMO_W-1)
// PORTS
//  clock        in   1      single clock, all state updates on posedge
//  reset_n      in   1      asynchronous, active-low reset
//  req          in   NCH    level request per channel; held until ack/err seen
//  ack          out  NCH    one-hot, 1-cycle pulse: granted transfer completed
//  err          out  NCH    one-hot, 1-cycle pulse: granted transfer timed out
//  slave_start  out  1      1-cycle pulse launching the slave
//  slave_ready  in   1      slave completion, sampled only in WORKING
//  busy         out  1      1 whenever state != IDLE
//  grant_id     out  IDW    index of channel currently served (valid while busy)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, ack=0, err=0, slave_start=0, busy=0,
//    grant_id=0, timeout count=0, rr pointer=0 (channel 0 highest priority first).
//  - All outputs are registered/decoded from registered state; no comb path req->outputs.
//  - States (2-bit+1 encoding, 5 states): IDLE, STARTING, WORKING, DONE, ABORT.
//  - IDLE: if |req, latch winner into grant_id, go STARTING; else stay.
//    Winner = first set req scanning ptr, ptr+1, ... NCH-1, 0, ... (modulo NCH wrap).
//  - STARTING: slave_start=1 this cycle only; clear counter; -> WORKING. ready ignored.
//  - WORKING: slave_ready=1 -> DONE (ready wins over timeout in same cycle);
//    else counter+1; counter==TIMEOUT-1 with no ready -> ABORT. Counter never wraps.
//  - DONE: ack[grant_id]=1 for exactly this cycle; ptr<=grant_id+1 (wrap to 0); -> IDLE.
//  - ABORT: err[grant_id]=1 for exactly this cycle; ptr<=grant_id+1 (wrap); -> IDLE.
//  - Min transaction: IDLE->STARTING->WORKING->DONE = ack 3 cycles after req sampled.
//  - Requests arriving/dropping while busy do not affect current grant; a req dropped
//    before service is simply not selected. ack and err never both high; at most 1 bit set.
//  - Back-to-back: after DONE/ABORT, IDLE always lasts >=1 cycle before next grant.
//  - reset_n low mid-transaction aborts silently (no ack/err), all state to reset values.
//  - NCH not power of two: ptr wraps from NCH-1 to 0; ids >= NCH never granted.
// STRUCTURE
//  - Package req_ack_pkg: state encoding localparams (ST_IDLE..ST_ABORT), state width.
//  - Sub-module rr_pick (combinational): inputs req[NCH], ptr[IDW]; outputs any, idx[IDW].
//    Top holds FSM, ptr, grant_id, timeout counter and output decode.
// TESTING
//  1 Single req[2]=1, slave_ready 2 cycles after start -> slave_start at t+1, ack=4'b0100
//    one cycle, grant_id=2, busy falls after DONE.
//  2 req=4'b1111 held, ready immediate -> grants 0,1,2,3,0 in order; each ack one-hot.
//  3 req[1]=1, slave_ready never -> err=4'b0010 exactly TIMEOUT cycles after WORKING
//    entry; no ack; ptr moves to 2.
//  4 ready asserted on the timeout cycle -> ack, not err.
//  5 reset_n pulsed low during WORKING -> outputs 0 immediately (async), no ack/err,
//    next req[3] served with ptr starting at 0.
//  6 NCH=3: req=3'b101 after serving ch2 -> next grant ch0 (wrap), never id 3.

Source files
------------

// File: rtl/req_ack_rr_ctrl_pkg.sv
// Shared definitions for the round-robin request/acknowledge controller.
// State encoding for the top-level FSM lives here so checkers and benches can reuse it.
package req_ack_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_STARTING = 3'd1,
        ST_WORKING  = 3'd2,
        ST_DONE     = 3'd3,
        ST_ABORT    = 3'd4
    } state_t;

endpackage

// File: rtl/req_ack_rr_ctrl_if.sv
// Requester/slave-engine bundle of the controller.
// The master side is the environment (requesters and slave engine); the slave side is the controller.
interface req_ack_rr_ctrl_if #(
    parameter int NCH = 4,
    parameter int IDW = 2
);
    logic [NCH-1:0] req;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] err;
    logic           slave_start;
    logic           slave_ready;
    logic           busy;
    logic [IDW-1:0] grant_id;

    modport master (
        output req, slave_ready,
        input  ack, err, slave_start, busy, grant_id
    );

    modport slave (
        input  req, slave_ready,
        output ack, err, slave_start, busy, grant_id
    );
endinterface

// File: rtl/req_ack_rr_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping at NCH.
// Works for non-power-of-two NCH because the rotated index is reduced modulo NCH.
module rr_pick #(
    parameter int NCH = 4,
    parameter int IDW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic           any,
    output logic [IDW-1:0] idx
);
    localparam logic [IDW:0] NCH_W = (IDW+1)'(NCH);

    logic [IDW:0] sum_s  [NCH];
    logic [IDW:0] cand_s [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_cand
        assign sum_s[i]  = {1'b0, ptr} + (IDW+1)'(i);
        assign cand_s[i] = (sum_s[i] >= NCH_W) ? (sum_s[i] - NCH_W) : sum_s[i];
    end

    // Scan from the farthest offset down so the nearest requester overrides.
    always_comb begin
        any = 1'b0;
        idx = {IDW{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            any = any | req[cand_s[i][IDW-1:0]];
            idx = req[cand_s[i][IDW-1:0]] ? cand_s[i][IDW-1:0] : idx;
        end
    end
endmodule

// File: rtl/req_ack_rr_ctrl.sv
// NCH requesters share one slave engine: round-robin grant, start pulse, ready wait with
// timeout, then a one-cycle ack (or err on timeout) to the granted channel.
module req_ack_rr_ctrl #(
    parameter int NCH     = 4,
    parameter int IDW     = $clog2(NCH),
    parameter int TMO_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    req_ack_rr_ctrl_if.slave bus
);
    import req_ack_pkg::*;

    localparam logic [IDW-1:0]   ID_LAST  = IDW'(NCH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t           state_r, state_nxt_s;
    logic [IDW-1:0]   ptr_r, ptr_nxt_s;
    logic [IDW-1:0]   grant_r, grant_nxt_s;
    logic [TMO_W-1:0] cnt_r, cnt_nxt_s;
    logic [NCH-1:0]   ack_r, err_r;
    logic             start_r, busy_r;
    logic             pick_any_s;
    logic [IDW-1:0]   pick_idx_s;
    logic [1:0]       rst_sync_r;
    logic             rst_int_n_s;

    function automatic logic [NCH-1:0] id_onehot(input logic [IDW-1:0] id);
        id_onehot = NCH'(1) << id;
    endfunction

    rr_pick #(.NCH(NCH), .IDW(IDW)) u_pick (
        .req (bus.req),
        .ptr (ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Reset synchroniser: assertion is immediate, release follows two clock edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_int_n_s = rst_sync_r[1];

    // FSM state, round-robin pointer, granted id and WORKING timeout counter.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            state_r <= ST_IDLE;
            ptr_r   <= {IDW{1'b0}};
            grant_r <= {IDW{1'b0}};
            cnt_r   <= {TMO_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            grant_r <= grant_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state logic; ready in WORKING takes priority over the timeout.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        grant_nxt_s = grant_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nxt_s = ST_STARTING;
                    grant_nxt_s = pick_idx_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_STARTING: begin
                cnt_nxt_s   = {TMO_W{1'b0}};
                state_nxt_s = ST_WORKING;
            end
            ST_WORKING: begin
                if (bus.slave_ready) begin
                    state_nxt_s = ST_DONE;
                end else if (cnt_r == TMO_LAST) begin
                    state_nxt_s = ST_ABORT;
                end else begin
                    cnt_nxt_s = cnt_r + TMO_W'(1);
                end
            end
            ST_DONE, ST_ABORT: begin
                ptr_nxt_s   = (grant_r == ID_LAST) ? {IDW{1'b0}} : (grant_r + IDW'(1));
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they decode.
    always_ff @(posedge clock or negedge rst_int_n_s) begin
        if (!rst_int_n_s) begin
            ack_r   <= {NCH{1'b0}};
            err_r   <= {NCH{1'b0}};
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            ack_r   <= (state_nxt_s == ST_DONE)  ? id_onehot(grant_nxt_s) : {NCH{1'b0}};
            err_r   <= (state_nxt_s == ST_ABORT) ? id_onehot(grant_nxt_s) : {NCH{1'b0}};
            start_r <= (state_nxt_s == ST_STARTING);
            busy_r  <= (state_nxt_s != ST_IDLE);
        end
    end

    assign bus.ack         = ack_r;
    assign bus.err         = err_r;
    assign bus.slave_start = start_r;
    assign bus.busy        = busy_r;
    assign bus.grant_id    = grant_r;
endmodule
